pll_loop: RTL and testbench
===========================

// Module: pll_loop
// PURPOSE
//  Digital loop filter downstream of the time stamp counter (tsc).
//  - On each pll_trig it takes the per-second phase error (pdiff_1pps) and frequency error (fdiff_1pps) between GPS PPS and TSC PPS.
//  - It runs a frequency-acquire / phase-track PI controller.
//  - Its output is a saturated DAC word that steers the 100 MHz VCXO, plus lock status and holdover flags.
// PARAMETERS
//  DAC_W       16          DAC word width (unsigned, offset binary)
//  ACC_W       40          integrator width (signed)
//  KP_SHIFT    4           proportional gain = pdiff >>> KP_SHIFT
//  KI_SHIFT    8           integral gain = pdiff >>> KI_SHIFT
//  KF_SHIFT    2           freq-acquire gain = fdiff <<< KF_SHIFT
//  FREQ_THR    32'd4       |fdiff| <= this -> enter phase tracking
//  LOCK_THR    32'd8       |pdiff| <= this counts as an in-lock sample
//  LOCK_CNT    8           consecutive in-lock samples to assert pll_locked
// PORTS
//  clk          in   1      100 MHz system clock
//  rst_n        in   1      async active-low reset
//  pll_en       in   1      loop enable; 0 = hold DAC, freeze state
//  gps_3dfix_d  in   1      GPS 3D fix valid (synchronized)
//  pll_trig     in   1      1-cycle strobe: pdiff/fdiff valid this cycle
//  pfd_status   in   1      1 = PFD measurement trustworthy
//  pdiff_1pps   in   32     signed phase error, clk cycles (+ = GPS late)
//  fdiff_1pps   in   32     signed freq error, clk cycles/s
//  dac_val      out  DAC_W  VCXO control word
//  dac_stb      out  1      1-cycle strobe: dac_val updated
//  pll_state    out  2      0 IDLE, 1 FREQ, 2 PHASE, 3 HOLD
//  pll_locked   out  1      phase lock indicator
//  pll_sat      out  1      sticky: integrator or DAC clipped since last trig accept
// BEHAVIOUR
//  Reset outputs:
//   - dac_val = 2**(DAC_W-1) (mid-scale); dac_stb = 0; pll_locked = 0; pll_sat = 0.
//   - pll_state = IDLE; integ = 0; lock counter = 0.
//  Accept condition: sample accepted iff pll_trig & pll_en & gps_3dfix_d & pfd_status.
//   - Non-accepted trig: no state/integ change, no dac_stb, lock counter cleared.
//  Pipeline, cycle counted from the accepted pll_trig = C0:
//   - C1: inputs registered.
//   - C2: terms computed; all shifts arithmetic, sign-extended to ACC_W.
//   - C3: integ update with saturation to signed ACC_W range (sets pll_sat).
//     ctl = integ_new + prop; dac = 2**(DAC_W-1) + ctl, clamped to [0, 2**DAC_W-1] (clip sets pll_sat).
//   - C4: dac_val registered, dac_stb = 1 for exactly one cycle.
//   - Fixed latency: 4 cycles trig -> dac_stb.
//  Re-trigger rule:
//   - A trig arriving while the pipeline is busy (C1..C3) is dropped.
//   - Triggers are nominally 1 s apart.
//  FSM, evaluated at C1 on accepted samples:
//   - IDLE: first accepted sample -> FREQ; no integ update on this sample.
//   - FREQ: integ += fdiff <<< KF_SHIFT; prop = 0.
//     If |fdiff| <= FREQ_THR -> PHASE.
//   - PHASE: prop = pdiff >>> KP_SHIFT; integ += pdiff >>> KI_SHIFT.
//     If |fdiff| > 4*FREQ_THR -> FREQ and lock counter cleared.
//   - Any state except IDLE: gps_3dfix_d == 0 -> HOLD immediately (any cycle).
//     dac_val frozen; lock counter cleared; pll_locked = 0.
//   - HOLD: gps_3dfix_d returns 1 -> FREQ; integ is retained, not cleared.
//   - pll_en == 0: state, integ and dac_val frozen; pll_en 0->1 resumes the same state.
//  Lock:
//   - In PHASE, each accepted sample with |pdiff| <= LOCK_THR increments a saturating 8-bit counter; otherwise the counter clears.
//   - pll_locked = (counter >= LOCK_CNT) && state == PHASE.
//  |x| of 32'h8000_0000 is treated as 32'h7FFF_FFFF (no overflow).
//  pll_sat: cleared at C1 of each accepted sample, set at C3 if any clip occurs.
//  Async reset mid-pipeline: everything returns to reset values; a partial update never strobes.
// TESTING
//  1. Reset, then trig with pdiff=0, fdiff=0, fix=1 -> IDLE->FREQ; dac_stb 4 cycles later; dac_val=16'h8000.
//  2. FREQ: fdiff=100 -> dac_val=0x8000+400.
//     Then fdiff=3 -> state PHASE; dac_val=0x8000+412.
//  3. PHASE: pdiff=+1600, fdiff=0 -> prop 100, integ +6; dac_val=previous integ+6+100+0x8000.
//  4. PHASE: pdiff=0 for 8 triggers -> pll_locked rises on 8th dac_stb.
//     Then pdiff=500 -> pll_locked=0 next sample.
//  5. gps_3dfix_d=0 -> HOLD, dac frozen, triggers ignored.
//     Fix=1 -> FREQ with integ retained.
//     pfd_status=0 trig -> no dac_stb.
//  6. fdiff=32'h7FFF_FFFF repeated -> dac_val=16'hFFFF, pll_sat=1.
//     rst_n pulse at C2 -> no dac_stb, dac_val=16'h8000.

Source files
------------

// File: rtl/pll_loop.sv
// PI loop filter for the VCXO: frequency acquisition followed by phase tracking.
// A four-stage pipeline turns each accepted PPS error sample into a saturated DAC word.
module pll_loop #(
  parameter int          DAC_W    = 16,
  parameter int          ACC_W    = 40,
  parameter int          KP_SHIFT = 4,
  parameter int          KI_SHIFT = 8,
  parameter int          KF_SHIFT = 2,
  parameter logic [31:0] FREQ_THR = 32'd4,
  parameter logic [31:0] LOCK_THR = 32'd8,
  parameter int          LOCK_CNT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_en,
  input  logic             gps_3dfix_d,
  input  logic             pll_trig,
  input  logic             pfd_status,
  input  logic [31:0]      pdiff_1pps,
  input  logic [31:0]      fdiff_1pps,
  output logic [DAC_W-1:0] dac_val,
  output logic             dac_stb,
  output logic [1:0]       pll_state,
  output logic             pll_locked,
  output logic             pll_sat
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FREQ = 2'd1, S_PHASE = 2'd2, S_HOLD = 2'd3} state_t;

  localparam logic [DAC_W-1:0] DAC_MID = {1'b1, {(DAC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t            state_q, state_d;
  logic [7:0]        lock_q, lock_d;
  logic              v1_q, v2_q, v3_q;
  logic [31:0]       p1_q, f1_q;
  logic [ACC_W-1:0]  inc2_q, prop2_q, integ_q;
  logic [ACC_W:0]    ctl3_q;
  logic              isat3_q;
  logic [DAC_W-1:0]  dac_q;
  logic              stb_q, sat_q;

  logic              busy, accept, kill;
  logic [31:0]       pabs, fabs;
  logic              f_small, f_large, p_small;

  // Most negative input maps to the largest positive magnitude instead of wrapping.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    if (!x[31])                  return x;
    else if (x == 32'h8000_0000) return 32'h7FFF_FFFF;
    else                         return -x;
  endfunction

  assign busy    = v1_q | v2_q | v3_q;
  assign accept  = pll_trig & pll_en & gps_3dfix_d & pfd_status & ~busy;
  assign kill    = ~pll_en | ~gps_3dfix_d;
  assign pabs    = abs32(p1_q);
  assign fabs    = abs32(f1_q);
  assign f_small = (fabs <= FREQ_THR);
  assign f_large = ({2'b00, fabs} > {FREQ_THR, 2'b00});
  assign p_small = (pabs <= LOCK_THR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (pll_en) begin
      if (state_q != S_IDLE && !gps_3dfix_d) begin
        state_d = S_HOLD;
      end else if (state_q == S_HOLD) begin
        state_d = S_FREQ;
      end else if (v1_q) begin
        case (state_q)
          S_IDLE:  state_d = S_FREQ;
          S_FREQ:  if (f_small) state_d = S_PHASE;
          S_PHASE: if (f_large) state_d = S_FREQ;
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_comb begin
    pll_state  = state_q;
    pll_locked = (state_q == S_PHASE) && (lock_q >= 8'(LOCK_CNT));
  end

  // A dropped or rejected trigger breaks the run of consecutive in-lock samples.
  always_comb begin
    lock_d = lock_q;
    if (!gps_3dfix_d) begin
      lock_d = '0;
    end else if (pll_trig && !accept) begin
      lock_d = '0;
    end else if (v1_q && pll_en) begin
      if (state_q == S_PHASE && !f_large && p_small)
        lock_d = (lock_q == 8'hFF) ? lock_q : lock_q + 8'd1;
      else
        lock_d = '0;
    end
  end

  logic signed [ACC_W-1:0] p_ext, f_ext;
  logic [ACC_W-1:0]        inc_c, prop_c;

  always_comb begin
    p_ext  = {{(ACC_W-32){p1_q[31]}}, p1_q};
    f_ext  = {{(ACC_W-32){f1_q[31]}}, f1_q};
    inc_c  = '0;
    prop_c = '0;
    case (state_q)
      S_FREQ:  inc_c = f_ext <<< KF_SHIFT;
      S_PHASE: begin
        inc_c  = p_ext >>> KI_SHIFT;
        prop_c = p_ext >>> KP_SHIFT;
      end
      default: ;
    endcase
  end

  logic [ACC_W:0]   isum, ctl_c;
  logic             iovf;
  logic [ACC_W-1:0] integ_new;

  always_comb begin
    isum      = {inc2_q[ACC_W-1], inc2_q} + {integ_q[ACC_W-1], integ_q};
    iovf      = isum[ACC_W] ^ isum[ACC_W-1];
    integ_new = !iovf ? isum[ACC_W-1:0] : (isum[ACC_W] ? ACC_MIN : ACC_MAX);
    ctl_c     = {integ_new[ACC_W-1], integ_new} + {prop2_q[ACC_W-1], prop2_q};
  end

  logic [ACC_W+1:0] dfull;
  logic             dneg, dovr, dclip;
  logic [DAC_W-1:0] dac_c;

  always_comb begin
    dfull = {ctl3_q[ACC_W], ctl3_q} + {{(ACC_W+2-DAC_W){1'b0}}, DAC_MID};
    dneg  = dfull[ACC_W+1];
    dovr  = |dfull[ACC_W:DAC_W];
    dclip = dneg | dovr;
    dac_c = dneg ? '0 : (dovr ? '1 : dfull[DAC_W-1:0]);
  end

  // Kills stop before the integrator commits, so integ and dac_val never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      p1_q    <= '0;
      f1_q    <= '0;
      inc2_q  <= '0;
      prop2_q <= '0;
      integ_q <= '0;
      ctl3_q  <= '0;
      isat3_q <= 1'b0;
      dac_q   <= DAC_MID;
      stb_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      v1_q  <= accept;
      v2_q  <= v1_q & ~kill;
      v3_q  <= v2_q & ~kill;
      stb_q <= v3_q;
      if (accept) begin
        p1_q <= pdiff_1pps;
        f1_q <= fdiff_1pps;
      end
      if (v1_q) begin
        inc2_q  <= inc_c;
        prop2_q <= prop_c;
      end
      if (v2_q && !kill) begin
        integ_q <= integ_new;
        ctl3_q  <= ctl_c;
        isat3_q <= iovf;
      end
      if (v3_q) dac_q <= dac_c;
      if (accept)                          sat_q <= 1'b0;
      else if (v3_q && (isat3_q || dclip)) sat_q <= 1'b1;
    end
  end

  assign dac_val = dac_q;
  assign dac_stb = stb_q;
  assign pll_sat = sat_q;

endmodule

// File: tb/tb_pll_loop.sv
// Bench for pll_loop: stimulus tables plus hand-built sequences for hold, retrigger and reset.
// Expected strobes are queued at trigger time and matched when dac_stb fires.
module tb_pll_loop;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pll_en = 1'b1;
  logic        gps_3dfix_d = 1'b1;
  logic        pll_trig = 1'b0;
  logic        pfd_status = 1'b1;
  logic [31:0] pdiff_1pps = '0;
  logic [31:0] fdiff_1pps = '0;
  logic [15:0] dac_val;
  logic        dac_stb;
  logic [1:0]  pll_state;
  logic        pll_locked;
  logic        pll_sat;

  pll_loop dut (
    .clk(clk), .rst_n(rst_n), .pll_en(pll_en), .gps_3dfix_d(gps_3dfix_d),
    .pll_trig(pll_trig), .pfd_status(pfd_status), .pdiff_1pps(pdiff_1pps),
    .fdiff_1pps(fdiff_1pps), .dac_val(dac_val), .dac_stb(dac_stb),
    .pll_state(pll_state), .pll_locked(pll_locked), .pll_sat(pll_sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] p, f;
    logic        fix, pfd, en, stb;
    logic [15:0] dac;
    logic [1:0]  st;
    logic        lk, sat;
  } vec_t;

  typedef struct {
    int          t;
    logic [15:0] dac;
    logic [1:0]  st;
    logic        lk, sat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] p, input logic [31:0] f,
                              input logic fix, input logic pfd, input logic en, input logic stb,
                              input logic [15:0] dac, input logic [1:0] st,
                              input logic lk, input logic sat);
    vec_t v;
    v.p = p; v.f = f; v.fix = fix; v.pfd = pfd; v.en = en; v.stb = stb;
    v.dac = dac; v.st = st; v.lk = lk; v.sat = sat;
    return v;
  endfunction

  task automatic push_exp(input logic [15:0] dac, input logic [1:0] st, input logic lk, input logic sat);
    exp_t e;
    e.t = cyc; e.dac = dac; e.st = st; e.lk = lk; e.sat = sat;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    chk({tag, "_drain"}, 64'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  // Scoreboard side: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (dac_stb === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_stb", 64'(dac_stb), 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("latency", 64'(cyc - mon_e.t), 4);
        chk("stb_dac", dac_val, mon_e.dac);
        chk("stb_state", pll_state, mon_e.st);
        chk("stb_locked", pll_locked, mon_e.lk);
        chk("stb_sat", pll_sat, mon_e.sat);
      end
    end
  end

  task automatic send(input vec_t v, input string tag);
    @(negedge clk);
    pdiff_1pps  = v.p;
    fdiff_1pps  = v.f;
    gps_3dfix_d = v.fix;
    pfd_status  = v.pfd;
    pll_en      = v.en;
    pll_trig    = 1'b1;
    if (v.stb) push_exp(v.dac, v.st, v.lk, v.sat);
    @(negedge clk);
    pll_trig = 1'b0;
    if (v.stb) chk({tag, "_sat_clear"}, pll_sat, 0);
    repeat (7) @(negedge clk);
    drain(tag);
    chk({tag, "_dac"}, dac_val, v.dac);
    chk({tag, "_state"}, pll_state, v.st);
    $display("vec %s p=%0d f=%0d fix=%b pfd=%b en=%b -> dac=%h state=%0d locked=%b sat=%b",
             tag, $signed(v.p), $signed(v.f), v.fix, v.pfd, v.en, dac_val, pll_state, pll_locked, pll_sat);
  endtask

  vec_t tbl[18];
  vec_t stbl[6];

  initial begin
    tbl[0]  = mk(32'd0,         32'd0,   1, 1, 1, 1, 16'h8000, 2'd1, 0, 0);
    tbl[1]  = mk(32'd0,         32'd100, 1, 1, 1, 1, 16'h8190, 2'd1, 0, 0);
    tbl[2]  = mk(32'd0,         32'd3,   1, 1, 1, 1, 16'h819C, 2'd2, 0, 0);
    tbl[3]  = mk(32'd1600,      32'd0,   1, 1, 1, 1, 16'h8206, 2'd2, 0, 0);
    for (int i = 4; i < 11; i++)
      tbl[i] = mk(32'd0,        32'd0,   1, 1, 1, 1, 16'h81A2, 2'd2, 0, 0);
    tbl[11] = mk(32'd0,         32'd0,   1, 1, 1, 1, 16'h81A2, 2'd2, 1, 0);
    tbl[12] = mk(32'd500,       32'd0,   1, 1, 1, 1, 16'h81C2, 2'd2, 0, 0);
    tbl[13] = mk(32'hFFFF_FF9C, 32'd0,   1, 1, 1, 1, 16'h819B, 2'd2, 0, 0);
    tbl[14] = mk(32'd0,         32'd17,  1, 1, 1, 1, 16'h81A2, 2'd1, 0, 0);
    tbl[15] = mk(32'd1600,      32'd0,   1, 0, 1, 0, 16'h81A2, 2'd1, 0, 0);
    tbl[16] = mk(32'd1600,      32'd0,   1, 1, 0, 0, 16'h81A2, 2'd1, 0, 0);
    tbl[17] = mk(32'd0,         32'd0,   1, 1, 1, 1, 16'h81A2, 2'd2, 0, 0);

    stbl[0] = mk(32'd0, 32'd17,        1, 1, 1, 1, 16'h81A6, 2'd1, 0, 0);
    stbl[1] = mk(32'd0, 32'h7FFF_FFFF, 1, 1, 1, 1, 16'hFFFF, 2'd1, 0, 1);
    stbl[2] = mk(32'd0, 32'h7FFF_FFFF, 1, 1, 1, 1, 16'hFFFF, 2'd1, 0, 1);
    stbl[3] = mk(32'd0, 32'h8000_0000, 1, 1, 1, 1, 16'hFFFF, 2'd1, 0, 1);
    stbl[4] = mk(32'd0, 32'h8000_0000, 1, 1, 1, 1, 16'h819E, 2'd1, 0, 0);
    stbl[5] = mk(32'd0, 32'h8000_0000, 1, 1, 1, 1, 16'h0000, 2'd1, 0, 1);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_dac", dac_val, 16'h8000);
    chk("rst_stb", dac_stb, 0);
    chk("rst_state", pll_state, 0);
    chk("rst_locked", pll_locked, 0);
    chk("rst_sat", pll_sat, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_state", pll_state, 0);

    for (int i = 0; i < 18; i++) send(tbl[i], $sformatf("t%0d", i));

    // Loss of fix: HOLD, triggers ignored, then FREQ with integrator retained
    @(negedge clk);
    gps_3dfix_d = 1'b0;
    @(negedge clk);
    chk("hold_state", pll_state, 3);
    chk("hold_locked", pll_locked, 0);
    send(mk(32'd1600, 32'd0, 0, 1, 1, 0, 16'h81A2, 2'd3, 0, 0), "hold_trig");
    gps_3dfix_d = 1'b1;
    @(negedge clk);
    chk("unhold_state", pll_state, 1);
    send(mk(32'd0, 32'd1, 1, 1, 1, 1, 16'h81A6, 2'd2, 0, 0), "retain");

    // Disabled loop freezes state even when fix drops
    @(negedge clk);
    pll_en = 1'b0;
    gps_3dfix_d = 1'b0;
    repeat (2) @(negedge clk);
    chk("en0_state", pll_state, 2);
    pll_en = 1'b1;
    gps_3dfix_d = 1'b1;
    @(negedge clk);
    chk("en1_state", pll_state, 2);

    // A trigger while the pipeline is busy is dropped
    @(negedge clk);
    pdiff_1pps = 32'd0; fdiff_1pps = 32'd0; pll_trig = 1'b1;
    push_exp(16'h81A6, 2'd2, 0, 0);
    @(negedge clk); pll_trig = 1'b0;
    @(negedge clk); pdiff_1pps = 32'd1600; pll_trig = 1'b1;
    @(negedge clk); pll_trig = 1'b0;
    repeat (7) @(negedge clk);
    drain("retrig");
    chk("retrig_dac", dac_val, 16'h81A6);
    $display("vec retrig -> dac=%h state=%0d", dac_val, pll_state);

    for (int i = 0; i < 6; i++) send(stbl[i], $sformatf("s%0d", i));

    // Reset during C2: no strobe, everything back to reset values
    @(negedge clk);
    pdiff_1pps = 32'd0; fdiff_1pps = 32'd100; pll_trig = 1'b1;
    @(negedge clk); pll_trig = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("midrst_dac", dac_val, 16'h8000);
    chk("midrst_state", pll_state, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(negedge clk);
    drain("midrst");
    chk("midrst_dac_after", dac_val, 16'h8000);
    chk("midrst_sat", pll_sat, 0);
    $display("vec midrst -> dac=%h state=%0d", dac_val, pll_state);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
